qpsk_upsampler: RTL and testbench

//  Downstream stage of the 2-bit IQ symbol source. Accepts QPSK dibits on an AXI-Stream-style input.

---
 rtl/qpsk_upsampler.sv | 120 ++++++++++++
 tb/tb_qpsk_upsampler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/qpsk_upsampler.sv
// QPSK dibit mapper and SPS-times upsampler with a one-entry pending buffer.
// Build option QPSK_ZERO_STUFF_EN: emit the mapped value on sample 0 only, zeros otherwise.
module qpsk_upsampler #(
    parameter int SPS = 4,
    parameter int DW  = 16,
    parameter int AMP = 23170
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [1:0]      in_data,
    output logic            in_ready,
    output logic            out_valid,
    output logic [2*DW-1:0] out_data,
    input  logic            out_ready
);

    localparam int CW = (SPS > 1) ? $clog2(SPS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SPS - 1);
    localparam logic signed [DW-1:0] AMP_POS = DW'(AMP);

    function automatic logic signed [DW-1:0] map_bit(input logic b);
        return b ? -AMP_POS : AMP_POS;
    endfunction

    function automatic logic [2*DW-1:0] map_dibit(input logic [1:0] d);
        logic signed [DW-1:0] i_s;
        logic signed [DW-1:0] q_s;
        i_s = map_bit(d[1]);
        q_s = map_bit(d[0]);
        return {i_s, q_s};
    endfunction

    logic            cur_valid_q, cur_valid_d;
    logic [2*DW-1:0] cur_sym_q,   cur_sym_d;
    logic [CW-1:0]   cnt_q,       cnt_d;
    logic            nxt_valid_q, nxt_valid_d;
    logic [1:0]      nxt_data_q,  nxt_data_d;
    logic [2*DW-1:0] out_data_q,  out_data_d;

    logic in_fire;
    logic out_fire;
    logic last_sample;
    logic in_taken;

    assign in_ready    = !rst && !nxt_valid_q;
    assign in_fire     = in_valid && in_ready;
    assign out_fire    = cur_valid_q && out_ready;
    assign last_sample = (cnt_q == CNT_LAST);

    always_comb begin
        cur_valid_d = cur_valid_q;
        cur_sym_d   = cur_sym_q;
        cnt_d       = cnt_q;
        nxt_valid_d = nxt_valid_q;
        nxt_data_d  = nxt_data_q;
        in_taken    = 1'b0;

        if (out_fire) begin
            if (!last_sample) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d = '0;
                if (nxt_valid_q) begin
                    cur_sym_d   = map_dibit(nxt_data_q);
                    nxt_valid_d = 1'b0;
                end else if (in_fire) begin
                    cur_sym_d = map_dibit(in_data);
                    in_taken  = 1'b1;
                end else begin
                    cur_valid_d = 1'b0;
                end
            end
        end

        // A dibit not absorbed by the symbol handoff goes to cur if idle, else waits in nxt.
        if (in_fire && !in_taken) begin
            if (!cur_valid_q) begin
                cur_valid_d = 1'b1;
                cur_sym_d   = map_dibit(in_data);
                cnt_d       = '0;
            end else begin
                nxt_valid_d = 1'b1;
                nxt_data_d  = in_data;
            end
        end
    end

    // Output word is precomputed from next state so out_data comes straight from a flop.
    always_comb begin
        out_data_d = cur_valid_d ? cur_sym_d : '0;
`ifdef QPSK_ZERO_STUFF_EN
        if (cnt_d != '0) begin
            out_data_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_valid_q <= 1'b0;
            cur_sym_q   <= '0;
            cnt_q       <= '0;
            nxt_valid_q <= 1'b0;
            nxt_data_q  <= '0;
            out_data_q  <= '0;
        end else begin
            cur_valid_q <= cur_valid_d;
            cur_sym_q   <= cur_sym_d;
            cnt_q       <= cnt_d;
            nxt_valid_q <= nxt_valid_d;
            nxt_data_q  <= nxt_data_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = cur_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_qpsk_upsampler.sv
// Scoreboard bench for qpsk_upsampler: SPS=4 main instance plus an SPS=1 instance.
module tb_qpsk_upsampler;

    localparam logic [15:0] P_AMP = 16'h5A82;
    localparam logic [15:0] N_AMP = 16'hA57E;

    logic        clk;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [1:0]  in_data;
    logic [31:0] out_data;
    logic        in_valid1, in_ready1, out_valid1, out_ready1;
    logic [1:0]  in_data1;
    logic [31:0] out_data1;

    qpsk_upsampler #(.SPS(4), .DW(16), .AMP(23170)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
    );

    qpsk_upsampler #(.SPS(1), .DW(16), .AMP(23170)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
        .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready1)
    );

    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [31:0] sb[$];
    int          win_vld = 0;
    int          win_first = -1;
    int          win_last = -1;
    int          cyc = 0;
    logic [31:0] snap;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d", total_cnt);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] amp_of(input logic b);
        return b ? N_AMP : P_AMP;
    endfunction

    // Monitor: expected samples enter at input accept, leave at output accept.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (in_valid && in_ready) begin
                for (int j = 0; j < 4; j++) begin
`ifdef QPSK_ZERO_STUFF_EN
                    sb.push_back((j == 0) ? {amp_of(in_data[1]), amp_of(in_data[0])} : 32'h0);
`else
                    sb.push_back({amp_of(in_data[1]), amp_of(in_data[0])});
`endif
                end
            end
            if (out_valid) begin
                win_vld++;
                if (win_first < 0) win_first = cyc;
                win_last = cyc;
            end
            if (out_valid && out_ready) begin
                chk("sample_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) chk("sample_value", 64'(out_data), 64'(sb.pop_front()));
            end
        end
    end

    task automatic send(input logic [1:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_window();
        win_vld   = 0;
        win_first = -1;
        win_last  = -1;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 2'b01;
        out_ready = 1'b1;
        in_valid1 = 1'b0;
        in_data1 = 2'b00;
        out_ready1 = 1'b1;

        // Reset state with in_valid asserted
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("release_in_ready", 64'(in_ready), 64'd1);
        chk("release_out_valid", 64'(out_valid), 64'd0);

        // Single dibit 01
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("latency_out_valid", 64'(out_valid), 64'd1);
        chk("first_sample", 64'(out_data), 64'h5A82A57E);
        repeat (4) @(posedge clk);
        #1;
        chk("single_done_out_valid", 64'(out_valid), 64'd0);
        chk("single_sb_empty", 64'(sb.size()), 64'd0);

        // Back-to-back stream, no bubbles
        repeat (2) @(posedge clk);
        #1;
        clear_window();
        send(2'b00);
        send(2'b01);
        send(2'b10);
        send(2'b11);
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("stream_vld_count", 64'(win_vld), 64'd16);
        chk("stream_contiguous", 64'(win_last - win_first + 1), 64'd16);
        chk("stream_sb_empty", 64'(sb.size()), 64'd0);

        // Backpressure mid-symbol
        send(2'b10);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        snap = out_data;
        in_valid = 1'b1;
        in_data = 2'b11;
        @(posedge clk);
        #1;
        chk("bp_nxt_full_in_ready", 64'(in_ready), 64'd0);
        in_data = 2'b00;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_data", 64'(out_data), 64'(snap));
            chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("bp_sb_empty", 64'(sb.size()), 64'd0);
        chk("bp_done_out_valid", 64'(out_valid), 64'd0);

        // Reset during sample 2 with nxt occupied
        send(2'b01);
        in_data = 2'b10;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("pre_rst_nxt_full", 64'(in_ready), 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_in_ready", 64'(in_ready), 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_window();
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_no_stale", 64'(win_vld), 64'd0);
        send(2'b11);
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_sb_empty", 64'(sb.size()), 64'd0);

        // SPS=1 instance: 00 then 11 back-to-back
        in_valid1 = 1'b1;
        in_data1 = 2'b00;
        chk("sps1_in_ready_a", 64'(in_ready1), 64'd1);
        @(posedge clk);
        #1;
        in_data1 = 2'b11;
        chk("sps1_out_valid_a", 64'(out_valid1), 64'd1);
        chk("sps1_sample_a", 64'(out_data1), 64'h5A825A82);
        chk("sps1_in_ready_b", 64'(in_ready1), 64'd1);
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        chk("sps1_out_valid_b", 64'(out_valid1), 64'd1);
        chk("sps1_sample_b", 64'(out_data1), 64'hA57EA57E);
        chk("sps1_in_ready_c", 64'(in_ready1), 64'd1);
        @(posedge clk);
        #1;
        chk("sps1_done", 64'(out_valid1), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
